// File: rtl/ofm_packer_pkg.sv
// Shared CNN package: packer FSM encodings, lane defaults and
// the AXI master write-channel state type.
package ofm_packer_pkg;

    localparam int OFM_DATA_WIDTH = 16;
    localparam int OFM_AXI_WIDTH  = 256;
    localparam int OFM_LANES      = OFM_AXI_WIDTH / OFM_DATA_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PACK = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;

    typedef enum logic [1:0] {
        AXI_IDLE = 2'd0,
        AXI_ADDR = 2'd1,
        AXI_DATA = 2'd2,
        AXI_RESP = 2'd3
    } axi_wr_state_t;

    localparam logic [19:0] WORD_CNT_MAX = 20'hFFFFF;

endpackage

// File: rtl/ofm_packer.sv
// Packs CNN output pixels into AXI-wide OFM words and pushes
// each completed word into the downstream OFM FIFO.
module ofm_packer
    import ofm_packer_pkg::*;
#(
    parameter int DATA_WIDTH = OFM_DATA_WIDTH,
    parameter int AXI_WIDTH  = OFM_AXI_WIDTH,
    parameter int LANES      = AXI_WIDTH / DATA_WIDTH
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  start,
    input  logic                  pix_valid,
    input  logic [DATA_WIDTH-1:0] pix_data,
    input  logic                  pix_last,
    output logic                  pix_ready,
    input  logic                  fifo_afull,
    output logic                  write,
    output logic [AXI_WIDTH-1:0]  wdata,
    output logic [19:0]           word_cnt,
    output logic                  layer_done
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LANE_MAX = LW'(LANES - 1);

    logic [1:0]           r_state;
    logic [LW-1:0]        r_lane;
    logic [AXI_WIDTH-1:0] r_word;
    logic                 r_last;
    logic [19:0]          r_cnt;

    logic w_accept;
    logic w_close;

    assign pix_ready  = (r_state == ST_PACK) && !fifo_afull;
    assign w_accept   = pix_valid && pix_ready;
    assign w_close    = (r_lane == LANE_MAX) || pix_last;

    // fifo_afull is deliberately not consulted in EMIT: the FIFO
    // keeps two entries of headroom for the word already in flight.
    assign write      = (r_state == ST_EMIT);
    assign layer_done = (r_state == ST_EMIT) && r_last;
    assign wdata      = r_word;
    assign word_cnt   = r_cnt;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= ST_IDLE;
            r_lane  <= '0;
            r_word  <= '0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_PACK;
                        r_lane  <= '0;
                        r_word  <= '0;
                        r_last  <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                ST_PACK: begin
                    if (w_accept) begin
                        r_word[r_lane*DATA_WIDTH +: DATA_WIDTH] <= pix_data;
                        if (w_close) begin
                            r_state <= ST_EMIT;
                            r_lane  <= '0;
                            r_last  <= pix_last;
                        end else begin
                            r_lane  <= r_lane + 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    // Cleared word makes a short final word zero-filled.
                    r_word  <= '0;
                    r_last  <= 1'b0;
                    r_state <= r_last ? ST_IDLE : ST_PACK;
                    if (r_cnt != WORD_CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
